// File: rtl/ticket_vending_fsm.sv
// Parametrised ticket vending controller: coin credit, destination price table, refund/change.
// Optional inactivity refund is compiled in when VEND_TIMEOUT_EN is defined.
module ticket_vending_fsm #(
    parameter int                            NUM_DEST    = 3,
    parameter int                            COIN_W      = 5,
    parameter int                            CREDIT_W    = 8,
    parameter logic [NUM_DEST*CREDIT_W-1:0]  PRICES      = {8'd20, 8'd15, 8'd10},
    parameter int                            TIMEOUT_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        coin_valid,
    input  logic [COIN_W-1:0]           coin_value,
    input  logic                        choice_valid,
    input  logic [$clog2(NUM_DEST)-1:0] choice,
    input  logic                        cancel,
    output logic [CREDIT_W-1:0]         credit,
    output logic                        ticket_valid,
    output logic [$clog2(NUM_DEST)-1:0] ticket_id,
    output logic                        change_valid,
    output logic [CREDIT_W-1:0]         change,
    output logic                        coin_reject,
    output logic                        insufficient,
    output logic                        timeout
);

    localparam int SEL_W = $clog2(NUM_DEST);

    typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, VEND = 2'd2, REFUND = 2'd3} state_t;

    state_t              state_r, state_s;
    logic [CREDIT_W-1:0] credit_s, change_s, post_s, price_s;
    logic [CREDIT_W:0]   sum_s;
    logic [SEL_W-1:0]    ticket_id_s;
    logic                ticket_valid_s, change_valid_s, coin_reject_s, insufficient_s, timeout_s;
    logic                coin_nz_s, coin_ok_s, choice_ok_s, activity_s, tmo_hit_s;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
        logic [CREDIT_W-1:0] p;
        p = {CREDIT_W{1'b0}};
        for (int i = 0; i < NUM_DEST; i++) begin
            p = (idx == SEL_W'(i)) ? PRICES[i*CREDIT_W +: CREDIT_W] : p;
        end
        return p;
    endfunction

    // Coin arithmetic: the extra sum bit flags overflow so the coin can be refused.
    always_comb begin
        coin_nz_s   = coin_valid && (coin_value != {COIN_W{1'b0}});
        sum_s       = {1'b0, credit} + {{(CREDIT_W + 1 - COIN_W){1'b0}}, coin_value};
        coin_ok_s   = coin_nz_s && !sum_s[CREDIT_W];
        post_s      = coin_ok_s ? sum_s[CREDIT_W-1:0] : credit;
        price_s     = price_of(choice);
        choice_ok_s = (int'(choice) < NUM_DEST);
        activity_s  = coin_valid || choice_valid || cancel;
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt_r;

    // Idle-cycle counter; held at zero outside COLLECT so entry always restarts it.
    always_ff @(posedge clk) begin
        if (rst || (state_r != COLLECT) || activity_s) begin
            tmo_cnt_r <= {TW{1'b0}};
        end else begin
            tmo_cnt_r <= tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
    end

    assign tmo_hit_s = (state_r == COLLECT) && !activity_s && (tmo_cnt_r == TW'(TIMEOUT_CYC - 1));
`else
    // Feature compiled out: never fires.
    assign tmo_hit_s = (TIMEOUT_CYC < 0);
`endif

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_s        = state_r;
        credit_s       = credit;
        ticket_valid_s = 1'b0;
        ticket_id_s    = {SEL_W{1'b0}};
        change_valid_s = 1'b0;
        change_s       = {CREDIT_W{1'b0}};
        coin_reject_s  = 1'b0;
        insufficient_s = 1'b0;
        timeout_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (coin_nz_s) begin
                    credit_s = {{(CREDIT_W - COIN_W){1'b0}}, coin_value};
                    state_s  = COLLECT;
                end else begin
                    credit_s = {CREDIT_W{1'b0}};
                end
            end
            COLLECT: begin
                coin_reject_s = coin_nz_s && sum_s[CREDIT_W];
                if (cancel) begin
                    state_s        = REFUND;
                    change_valid_s = 1'b1;
                    change_s       = post_s;
                    credit_s       = {CREDIT_W{1'b0}};
                end else if (choice_valid) begin
                    if (choice_ok_s && (post_s >= price_s)) begin
                        state_s        = VEND;
                        ticket_valid_s = 1'b1;
                        ticket_id_s    = choice;
                        change_valid_s = 1'b1;
                        change_s       = post_s - price_s;
                        credit_s       = {CREDIT_W{1'b0}};
                    end else begin
                        insufficient_s = 1'b1;
                        credit_s       = post_s;
                    end
                end else if (tmo_hit_s) begin
                    state_s        = REFUND;
                    change_valid_s = 1'b1;
                    change_s       = post_s;
                    timeout_s      = 1'b1;
                    credit_s       = {CREDIT_W{1'b0}};
                end else begin
                    credit_s = post_s;
                end
            end
            VEND, REFUND: begin
                coin_reject_s = coin_nz_s;
                credit_s      = {CREDIT_W{1'b0}};
                state_s       = IDLE;
            end
            default: begin
                credit_s = {CREDIT_W{1'b0}};
                state_s  = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards credit without a change pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            credit       <= {CREDIT_W{1'b0}};
            ticket_valid <= 1'b0;
            ticket_id    <= {SEL_W{1'b0}};
            change_valid <= 1'b0;
            change       <= {CREDIT_W{1'b0}};
            coin_reject  <= 1'b0;
            insufficient <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state_r      <= state_s;
            credit       <= credit_s;
            ticket_valid <= ticket_valid_s;
            ticket_id    <= ticket_id_s;
            change_valid <= change_valid_s;
            change       <= change_s;
            coin_reject  <= coin_reject_s;
            insufficient <= insufficient_s;
            timeout      <= timeout_s;
        end
    end

endmodule

// File: tb/tb_ticket_vending_fsm.sv
// Scoreboard bench for ticket_vending_fsm: a behavioural model queues the expected
// registered outputs for every cycle, compared one cycle later.
module tb_ticket_vending_fsm;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst, coin_valid, choice_valid, cancel;
    logic [4:0] coin_value;
    logic [1:0] choice, ticket_id;
    logic [7:0] credit, change;
    logic       ticket_valid, change_valid, coin_reject, insufficient, timeout;

    ticket_vending_fsm #(.NUM_DEST(3), .COIN_W(5), .CREDIT_W(8),
                         .PRICES({8'd20, 8'd15, 8'd10}), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
        .choice_valid(choice_valid), .choice(choice), .cancel(cancel),
        .credit(credit), .ticket_valid(ticket_valid), .ticket_id(ticket_id),
        .change_valid(change_valid), .change(change), .coin_reject(coin_reject),
        .insufficient(insufficient), .timeout(timeout));

    always #5 clk = ~clk;

    typedef struct {
        int credit; int tv; int tid; int cv; int chg; int rej; int ins; int tmo;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   price[3] = '{10, 15, 20};
    int   m_state = 0;   // 0 idle, 1 collect, 2 vend, 3 refund
    int   m_credit = 0;
    int   m_idle = 0;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_vec++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic exp_t model(input int r, input int cvld, input int cval,
                                   input int chv, input int ch, input int can);
        exp_t e;
        int   post, sum;
        e = '{0, 0, 0, 0, 0, 0, 0, 0};
        if (r != 0) begin
            m_state = 0; m_credit = 0; m_idle = 0;
        end else begin
            case (m_state)
                0: begin
                    if (cvld != 0 && cval != 0) begin
                        m_credit = cval; m_state = 1; m_idle = 0;
                    end
                end
                1: begin
                    sum  = m_credit + ((cvld != 0) ? cval : 0);
                    post = m_credit;
                    if (cvld != 0 && cval != 0) begin
                        if (sum > 255) e.rej = 1;
                        else post = sum;
                    end
                    if (cvld != 0 || chv != 0 || can != 0) m_idle = 0;
                    else m_idle++;
                    if (can != 0) begin
                        e.cv = 1; e.chg = post; m_credit = 0; m_state = 3;
                    end else if (chv != 0) begin
                        if (ch < 3 && post >= price[ch]) begin
                            e.tv = 1; e.tid = ch; e.cv = 1; e.chg = post - price[ch];
                            m_credit = 0; m_state = 2;
                        end else begin
                            e.ins = 1; m_credit = post;
                        end
`ifdef VEND_TIMEOUT_EN
                    end else if (m_idle == TMO) begin
                        e.cv = 1; e.chg = post; e.tmo = 1; m_credit = 0; m_state = 3;
`endif
                    end else begin
                        m_credit = post;
                    end
                end
                default: begin
                    if (cvld != 0 && cval != 0) e.rej = 1;
                    m_credit = 0; m_state = 0;
                end
            endcase
        end
        e.credit = m_credit;
        return e;
    endfunction

    task automatic step(input int r, input int cvld, input int cval,
                        input int chv, input int ch, input int can);
        exp_t e;
        rst = (r != 0); coin_valid = (cvld != 0); coin_value = 5'(cval);
        choice_valid = (chv != 0); choice = 2'(ch); cancel = (can != 0);
        q.push_back(model(r, cvld, cval, chv, ch, can));
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("credit", int'(credit), e.credit);
        check("ticket_valid", int'(ticket_valid), e.tv);
        if (e.tv != 0) check("ticket_id", int'(ticket_id), e.tid);
        check("change_valid", int'(change_valid), e.cv);
        check("change", int'(change), e.chg);
        check("coin_reject", int'(coin_reject), e.rej);
        check("insufficient", int'(insufficient), e.ins);
        check("timeout", int'(timeout), e.tmo);
    endtask

    task automatic coin(input int v);
        step(0, 1, v, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; coin_valid = 1'b0; coin_value = 5'd0;
        choice_valid = 1'b0; choice = 2'd0; cancel = 1'b0;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        // exact-price purchase, destination 0
        coin(10); step(0, 0, 0, 1, 0, 0); idle(1);
        // 5+5+10 then destination 1
        coin(5); coin(5); coin(10); step(0, 0, 0, 1, 1, 0); idle(1);
        // short credit, then coin and choice in the same cycle
        coin(5); step(0, 0, 0, 1, 2, 0); step(0, 1, 20, 1, 2, 0); idle(1);
        // cancel with a coin in the same cycle
        coin(10); step(0, 1, 5, 0, 0, 1); idle(1);
        // overflow near full credit, then coins during REFUND and VEND
        for (int i = 0; i < 8; i++) coin(31);
        coin(2); coin(10); step(0, 0, 0, 1, 3, 0); coin(0);
        step(0, 0, 0, 0, 0, 1); coin(7); idle(1);
        coin(20); step(0, 0, 0, 1, 1, 0); coin(9); idle(1);
        // choice and cancel ignored in IDLE
        step(0, 0, 0, 1, 0, 0); step(0, 0, 0, 0, 0, 1);
        // inactivity: refunds after TMO cycles only with the timeout build
        coin(5); idle(TMO + 4); step(0, 0, 0, 0, 0, 1); idle(1);
        // reset mid-purchase
        coin(15); step(1, 0, 0, 0, 0, 0); idle(2);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0) ? 1 : 0,
                 ($urandom_range(0, 2) == 0) ? 1 : 0, int'($urandom_range(0, 31)),
                 ($urandom_range(0, 4) == 0) ? 1 : 0, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 14) == 0) ? 1 : 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
